imsharp_window_ctrl: RTL and testbench
======================================

// Module: imsharp_window_ctrl
// PURPOSE
//   Front-end sequencer for the imsharp 5x5 sharpening datapath. Accepts a raster-order
//   8-bit pixel stream and keeps 4 line buffers plus a 5x5 window register.
//   Emits one zero-padded 5x5 window per image pixel, ordered exactly as imsharp
//   input_pixel_1..25 expects, under valid/ready flow control on both sides.
// PARAMETERS
//   IMG_W   128  image width in pixels (>=5)
//   IMG_H   128  image height in pixels (>=5)
//   K       5    kernel size; fixed at 5, not a free parameter
// PORTS
//   clk         in   1     clock, rising edge
//   Reset       in   1     asynchronous, active-low reset
//   start       in   1     1-cycle pulse that begins a frame; ignored while busy=1
//   in_pixel    in   8     input pixel, raster order (row-major)
//   in_valid    in   1     in_pixel is valid
//   in_ready    out  1     controller accepts in_pixel this cycle
//   win_pixels  out  200   window; byte k=[8k+7:8k] is pixel(r+h-2,c+w-2), k=h*5+w
//   win_valid   out  1     win_pixels/win_row/win_col are valid
//   win_ready   in   1     downstream accepts the window
//   win_row     out  16    centre row r of the current window
//   win_col     out  16    centre column c of the current window
//   busy        out  1     frame in progress
//   frame_done  out  1     1-cycle pulse after the last window (r=IMG_H-1, c=IMG_W-1) is accepted
// BEHAVIOUR
//   Reset (Reset=0): all outputs are 0. FSM=IDLE. Line-buffer contents are don't-care.
//   FSM: IDLE -start-> RUN -last step done-> DRAIN -last window accepted-> DONE -> IDLE.
//     DONE lasts 1 cycle; frame_done=1 in DONE only. busy=1 in RUN and DRAIN.
//   Virtual scan: position (vr,vc), vr in 0..IMG_H+1, vc in 0..IMG_W+1, row-major.
//     Both counters are cleared on start.
//     Real position (vr<IMG_H and vc<IMG_W): a step consumes one input pixel.
//     Padding position: a step synthesises pixel 0 and consumes no input.
//   Step condition (RUN): (real ? in_valid : 1) and (!win_valid or win_ready).
//     in_ready = RUN and real position and (!win_valid or win_ready).
//     in_ready is combinational and never depends on in_valid.
//   Each step:
//     - writes the pixel into the line buffers (depth IMG_W+2, column vc)
//     - shifts a new column into the window (4 buffered rows plus the new pixel)
//     - advances (vc,vr) with wrap vc=IMG_W+1 -> 0, vr++
//   Window emit: a step at vr>=2 and vc>=2 loads win_pixels on the same clock edge.
//     Centre is (vr-2, vc-2). win_valid=1 on the next cycle.
//     Latency: window (r,c) is valid 1 cycle after the step at (r+2,c+2).
//   Zero padding in the emitted window:
//     - row index < 0: byte forced to 0 (masks stale line-buffer data from earlier frames)
//     - column index < 0: byte forced to 0
//     - row >= IMG_H or column >= IMG_W: 0 by construction (synthesised pixels)
//   Output hold: while win_valid=1 and win_ready=0, win_pixels, win_row and win_col stay
//     stable and no step occurs. With win_valid=1 and win_ready=1, a step in the same cycle
//     loads the next window, giving back-to-back throughput of 1 window/cycle.
//   Step count: (IMG_H+2)*(IMG_W+2) steps per frame; exactly IMG_H*IMG_W windows are emitted.
//   DRAIN: starts after the final step (vr=IMG_H+1, vc=IMG_W+1) and waits for that window's
//     handshake.
//   start while busy or in DONE: ignored. in_pixel is ignored when in_ready=0.
//   Reset mid-frame: immediate return to IDLE. The partial frame is discarded.
//     The next frame is unaffected because of the row<0 masking.
//   Counter width: 16 bits; IMG_W+2 and IMG_H+2 must be < 65536.
// TESTING  (IMG_W=IMG_H=8 unless stated)
//   All-255 frame, win_ready=1:
//     -> 64 windows with rows/cols in raster order.
//     -> Window (0,0): bytes k in {12,13,14,17,18,19,22,23,24}=255, all others 0.
//     -> Window (3,3): all 25 bytes =255. Exactly one frame_done.
//   Ramp pixel(r,c)=r*8+c:
//     -> Window (4,4): k0=18, k12=36, k24=54.
//     -> Window (7,7): k0=45, k6=54, k12=63; bytes with row or column index >7 are 0.
//   win_ready=0 for 10 cycles after the 20th window:
//     -> win_pixels and win_col stay stable and in_ready=0.
//     -> After release, the sequence continues with no window lost or duplicated.
//   Random in_valid gaps (~50%) and random win_ready:
//     -> window sequence is bit-identical to the gap-free run; 64 windows, 1 frame_done.
//   Back-to-back frames: frame A all-255, then frame B all-0.
//     -> Every B window is all 0, with no 255 leaking from A's line buffers.
//   Reset pulled low mid-frame at window 30:
//     -> All outputs are 0 within the same cycle.
//     -> After a new start with the ramp frame, results match the ramp test.
//     -> A start issued while busy=1 produces no change.

Source files
------------

// File: rtl/imsharp_window_ctrl.sv
// imsharp_window_ctrl: raster-order pixel stream to zero-padded 5x5 windows.
// A virtual scan of (IMG_H+2) x (IMG_W+2) positions drives four column-indexed
// line buffers and a 5x5 shift window; every step at vr>=2, vc>=2 emits the
// window centred on (vr-2, vc-2) under valid/ready flow control.
module imsharp_window_ctrl #(
  parameter int IMG_W = 128,
  parameter int IMG_H = 128
) (
  input  logic         clk,
  input  logic         Reset,
  input  logic         start,
  input  logic [7:0]   in_pixel,
  input  logic         in_valid,
  output logic         in_ready,
  output logic [199:0] win_pixels,
  output logic         win_valid,
  input  logic         win_ready,
  output logic [15:0]  win_row,
  output logic [15:0]  win_col,
  output logic         busy,
  output logic         frame_done
);

  localparam int K     = 5;
  localparam int DEPTH = IMG_W + 2;
  localparam int AW    = $clog2(DEPTH);
  localparam logic [15:0] W16    = 16'(IMG_W);
  localparam logic [15:0] H16    = 16'(IMG_H);
  localparam logic [15:0] LAST_C = 16'(IMG_W + 1);
  localparam logic [15:0] LAST_R = 16'(IMG_H + 1);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;
  state_t state, state_nxt;

  logic [15:0]   vr, vc;
  logic          real_pos, out_free, step, emit, last_step;
  logic [7:0]    pix;
  logic [AW-1:0] col_idx;

  // lb[0] holds row vr-1 at column vc, lb[3] holds row vr-4
  logic [7:0]    lb [K-1][DEPTH];
  // win_sh[h][w]: row vr-4+h, column vc-4+w (w=4 newest column)
  logic [7:0]    win_sh [K][K];
  logic [7:0]    sh_nxt [K][K];
  logic [7:0]    new_col [K];
  logic [199:0]  win_nxt;

  assign real_pos  = (vr < H16) && (vc < W16);
  assign out_free  = !win_valid || win_ready;
  assign in_ready  = (state == RUN) && real_pos && out_free;
  assign step      = (state == RUN) && (real_pos ? in_valid : 1'b1) && out_free;
  assign emit      = step && (vr >= 16'd2) && (vc >= 16'd2);
  assign last_step = step && (vr == LAST_R) && (vc == LAST_C);
  assign pix       = real_pos ? in_pixel : 8'd0;
  assign col_idx   = vc[AW-1:0];

  // State register
  always_ff @(posedge clk or negedge Reset) begin
    if (!Reset) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state and status outputs
  always_comb begin
    state_nxt  = state;
    busy       = 1'b0;
    frame_done = 1'b0;
    unique case (state)
      IDLE:    if (start) state_nxt = RUN;
      RUN:     begin
                 busy = 1'b1;
                 if (last_step) state_nxt = DRAIN;
               end
      DRAIN:   begin
                 busy = 1'b1;
                 if (win_valid && win_ready) state_nxt = DONE;
               end
      DONE:    begin
                 frame_done = 1'b1;
                 state_nxt  = IDLE;
               end
      default: state_nxt = IDLE;
    endcase
  end

  // Virtual scan position, cleared on an accepted start
  always_ff @(posedge clk or negedge Reset) begin
    if (!Reset) begin
      vr <= '0;
      vc <= '0;
    end else if (state == IDLE && start) begin
      vr <= '0;
      vc <= '0;
    end else if (step) begin
      if (vc == LAST_C) begin
        vc <= '0;
        vr <= vr + 16'd1;
      end else begin
        vc <= vc + 16'd1;
      end
    end
  end

  // Incoming column: four buffered rows (oldest first) plus the new pixel
  always_comb begin
    new_col[K-1] = pix;
    for (int h = 0; h < K-1; h++) new_col[h] = lb[K-2-h][col_idx];
  end

  // Shifted window and its masked output image; rows/columns left of or
  // above the frame are forced to 0 so stale line-buffer data never leaks
  always_comb begin
    win_nxt = '0;
    for (int h = 0; h < K; h++) begin
      for (int w = 0; w < K-1; w++) sh_nxt[h][w] = win_sh[h][w+1];
      sh_nxt[h][K-1] = new_col[h];
    end
    for (int h = 0; h < K; h++)
      for (int w = 0; w < K; w++)
        if ((vr >= 16'(4 - h)) && (vc >= 16'(4 - w)))
          win_nxt[8*(h*K+w) +: 8] = sh_nxt[h][w];
  end

  // Line buffers and shift window advance on every step (data path, no reset)
  always_ff @(posedge clk) begin
    if (step) begin
      lb[0][col_idx] <= pix;
      lb[1][col_idx] <= lb[0][col_idx];
      lb[2][col_idx] <= lb[1][col_idx];
      lb[3][col_idx] <= lb[2][col_idx];
      win_sh         <= sh_nxt;
    end
  end

  // Output window register; held while the consumer stalls
  always_ff @(posedge clk or negedge Reset) begin
    if (!Reset) begin
      win_valid  <= 1'b0;
      win_pixels <= '0;
      win_row    <= '0;
      win_col    <= '0;
    end else if (emit) begin
      win_valid  <= 1'b1;
      win_pixels <= win_nxt;
      win_row    <= vr - 16'd2;
      win_col    <= vc - 16'd2;
    end else if (win_ready) begin
      win_valid  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_imsharp_window_ctrl.sv
// Bench for imsharp_window_ctrl (8x8 image): reference windows are pushed to a
// scoreboard when a frame is launched and popped on every window handshake.
module tb_imsharp_window_ctrl;

  localparam int W    = 8;
  localparam int H    = 8;
  localparam int NPIX = W * H;

  logic         clk = 1'b0;
  logic         Reset;
  logic         start;
  logic [7:0]   in_pixel;
  logic         in_valid;
  logic         in_ready;
  logic [199:0] win_pixels;
  logic         win_valid;
  logic         win_ready;
  logic [15:0]  win_row;
  logic [15:0]  win_col;
  logic         busy;
  logic         frame_done;

  typedef struct {
    logic [199:0] pix;
    logic [15:0]  row;
    logic [15:0]  col;
  } win_t;

  win_t         exp_q[$];
  logic [7:0]   img [NPIX];
  logic [199:0] w00_ref;
  int           n_checks = 0;
  int           n_errors = 0;

  imsharp_window_ctrl #(.IMG_W(W), .IMG_H(H)) dut (
    .clk        (clk),
    .Reset      (Reset),
    .start      (start),
    .in_pixel   (in_pixel),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .win_pixels (win_pixels),
    .win_valid  (win_valid),
    .win_ready  (win_ready),
    .win_row    (win_row),
    .win_col    (win_col),
    .busy       (busy),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [199:0] got, input logic [199:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // mode 0: all 255, mode 1: ramp r*8+c, mode 2: all 0
  task automatic load_frame(input int mode);
    win_t e;
    int   rr, cc;
    for (int i = 0; i < NPIX; i++)
      img[i] = (mode == 0) ? 8'hFF : (mode == 1) ? 8'(i) : 8'h00;
    for (int r = 0; r < H; r++) begin
      for (int c = 0; c < W; c++) begin
        e.pix = '0;
        e.row = 16'(r);
        e.col = 16'(c);
        for (int h = 0; h < 5; h++) begin
          for (int w = 0; w < 5; w++) begin
            rr = r + h - 2;
            cc = c + w - 2;
            if (rr >= 0 && rr < H && cc >= 0 && cc < W)
              e.pix[8*(h*5+w) +: 8] = img[rr*W + cc];
          end
        end
        exp_q.push_back(e);
      end
    end
  endtask

  task automatic spot_checks(input int mode);
    if (mode == 0 && win_row == 16'd0 && win_col == 16'd0)
      check_eq("w00_all255", win_pixels, w00_ref);
    if (mode == 0 && win_row == 16'd3 && win_col == 16'd3)
      check_eq("w33_all255", win_pixels, {200{1'b1}});
    if (mode == 1 && win_row == 16'd4 && win_col == 16'd4) begin
      check_eq("w44_k0",  200'(win_pixels[7:0]),     200'(18));
      check_eq("w44_k12", 200'(win_pixels[103:96]),  200'(36));
      check_eq("w44_k24", 200'(win_pixels[199:192]), 200'(54));
    end
    if (mode == 1 && win_row == 16'd7 && win_col == 16'd7) begin
      check_eq("w77_k0",  200'(win_pixels[7:0]),    200'(45));
      check_eq("w77_k6",  200'(win_pixels[55:48]),  200'(54));
      check_eq("w77_k12", 200'(win_pixels[103:96]), 200'(63));
      for (int k = 0; k < 25; k++)
        if ((k / 5) > 2 || (k % 5) > 2)
          check_eq("w77_pad", 200'(win_pixels[8*k +: 8]), 200'(0));
    end
  endtask

  task automatic run_frame(input int mode, input bit gaps, input bit rnd_ready,
                           input bit stall20, input int abort_at, input bit extra_start);
    win_t         e;
    int           pix_idx, nwin, nfd, cyc, stall_left;
    bit           hs_in, hs_out, done, aborted, snap_pending;
    logic [199:0] hold_pix;
    logic [15:0]  hold_row, hold_col;

    load_frame(mode);
    check_eq("idle_busy", 200'(busy), 200'(0));
    @(posedge clk); #1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    pix_idx = 0; nwin = 0; nfd = 0; cyc = 0; stall_left = 0;
    done = 0; aborted = 0; snap_pending = 0;
    hold_pix = '0; hold_row = '0; hold_col = '0;
    in_valid  = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
    in_pixel  = img[0];
    win_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;

    while (!done && !aborted && cyc < 3000) begin
      @(negedge clk);
      if (cyc == 0) check_eq("busy_run", 200'(busy), 200'(1));
      if (frame_done) nfd++;
      hs_in  = in_valid && in_ready;
      hs_out = win_valid && win_ready;
      if (stall_left > 0) begin
        if (snap_pending) begin
          hold_pix = win_pixels; hold_row = win_row; hold_col = win_col;
          snap_pending = 0;
        end else begin
          check_eq("hold_pixels", win_pixels, hold_pix);
          check_eq("hold_row", 200'(win_row), 200'(hold_row));
          check_eq("hold_col", 200'(win_col), 200'(hold_col));
        end
        check_eq("hold_valid", 200'(win_valid), 200'(1));
        check_eq("hold_in_ready", 200'(in_ready), 200'(0));
        stall_left--;
      end
      if (hs_out) begin
        if (exp_q.size() == 0) begin
          check_eq("extra_window", 200'(1), 200'(hs_in && 1'b0));
        end else begin
          e = exp_q.pop_front();
          check_eq("win_pixels", win_pixels, e.pix);
          check_eq("win_row", 200'(win_row), 200'(e.row));
          check_eq("win_col", 200'(win_col), 200'(e.col));
          spot_checks(mode);
        end
        nwin++;
        if (stall20 && nwin == 20) begin
          stall_left = 10;
          snap_pending = 1;
        end
      end
      if (abort_at > 0 && nwin == abort_at) begin
        Reset = 1'b0;
        #1;
        check_eq("rst_in_ready", 200'(in_ready), 200'(0));
        check_eq("rst_win_valid", 200'(win_valid), 200'(0));
        check_eq("rst_busy", 200'(busy), 200'(0));
        check_eq("rst_frame_done", 200'(frame_done), 200'(0));
        check_eq("rst_win_pixels", win_pixels, 200'(0));
        check_eq("rst_win_row", 200'(win_row), 200'(0));
        check_eq("rst_win_col", 200'(win_col), 200'(0));
        exp_q.delete();
        in_valid = 1'b0; start = 1'b0; win_ready = 1'b1;
        @(posedge clk); #1;
        Reset = 1'b1;
        aborted = 1;
      end else begin
        if (nfd > 0) done = 1;
        @(posedge clk); #1;
        if (hs_in) pix_idx++;
        in_valid  = (pix_idx < NPIX) && (gaps ? 1'($urandom_range(0, 1)) : 1'b1);
        in_pixel  = (in_valid) ? img[pix_idx] : 8'($urandom);
        win_ready = (stall_left > 0) ? 1'b0 : (rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1);
        start     = extra_start && (cyc == 40);
        cyc++;
      end
    end

    if (!aborted) begin
      in_valid = 1'b0;
      start = 1'b0;
      repeat (4) begin
        @(negedge clk);
        if (frame_done) nfd++;
      end
      check_eq("frame_done_count", 200'(nfd), 200'(1));
      check_eq("window_count", 200'(nwin), 200'(NPIX));
      check_eq("scoreboard_empty", 200'(exp_q.size()), 200'(0));
      check_eq("busy_after", 200'(busy), 200'(0));
      exp_q.delete();
    end
  endtask

  initial begin
    int ks [9] = '{12, 13, 14, 17, 18, 19, 22, 23, 24};
    w00_ref = '0;
    for (int i = 0; i < 9; i++) w00_ref[8*ks[i] +: 8] = 8'hFF;

    Reset = 1'b0; start = 1'b0; in_valid = 1'b0; in_pixel = 8'h00; win_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_eq("reset_in_ready", 200'(in_ready), 200'(0));
    check_eq("reset_win_valid", 200'(win_valid), 200'(0));
    check_eq("reset_busy", 200'(busy), 200'(0));
    check_eq("reset_frame_done", 200'(frame_done), 200'(0));
    check_eq("reset_win_pixels", win_pixels, 200'(0));
    check_eq("reset_win_row", 200'(win_row), 200'(0));
    check_eq("reset_win_col", 200'(win_col), 200'(0));
    Reset = 1'b1;

    run_frame(0, 1'b0, 1'b0, 1'b0, 0, 1'b0);   // all-255
    run_frame(1, 1'b0, 1'b0, 1'b0, 0, 1'b0);   // ramp
    run_frame(1, 1'b0, 1'b0, 1'b1, 0, 1'b0);   // ramp, stall after 20th window
    run_frame(1, 1'b1, 1'b1, 1'b0, 0, 1'b0);   // ramp, random gaps and ready
    run_frame(0, 1'b0, 1'b0, 1'b0, 0, 1'b0);   // frame A all-255
    run_frame(2, 1'b0, 1'b0, 1'b0, 0, 1'b0);   // frame B all-0
    run_frame(1, 1'b0, 1'b0, 1'b0, 30, 1'b0);  // reset at window 30
    run_frame(1, 1'b0, 1'b0, 1'b0, 0, 1'b1);   // ramp again, stray start while busy

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
